// File: rtl/msx_ppi_io_responder_pkg.sv
// Shared definitions for the MSX Z80 I/O responder (8255-lite on ports A8h-ABh).
// Contents: port address constants, FSM state type, reset values and the
// port C bit set/reset / mode-word helper.
package msx_io_pkg;

  localparam logic [7:0] PORT_SLOT = 8'hA8;
  localparam logic [7:0] PORT_KBD  = 8'hA9;
  localparam logic [7:0] PORT_C    = 8'hAA;
  localparam logic [7:0] PORT_CTRL = 8'hAB;

  // A[7:2] shared by all four PPI ports
  localparam logic [5:0] PORT_BASE = 6'b101010;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  localparam logic [7:0] RST_SLOT_SEL = 8'h00;
  localparam logic [7:0] RST_PORT_C   = 8'h00;
  localparam logic [7:0] RST_D_OUT    = 8'h00;
  localparam logic       RST_D_OE     = 1'b0;
  localparam logic       RST_WAIT_N   = 1'b1;
  localparam logic [7:0] RST_CNT      = 8'h00;

  // Control-port write: bit 7 set is a mode word (clears port C),
  // otherwise bits 3:1 select the port C bit and bit 0 is its new value.
  function automatic logic [7:0] port_c_ctrl(input logic [7:0] cur, input logic [7:0] ctl);
    logic [7:0] nxt;
    nxt = cur;
    case (ctl[7])
      1'b1:    nxt = RST_PORT_C;
      1'b0:    nxt[ctl[3:1]] = ctl[0];
      default: nxt = cur;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/msx_ppi_io_responder_if.sv
// Z80 I/O bus bundle between the bus glue (master) and the responder (slave).
// a/d_in/strobes come from the CPU side; d_out/d_oe/wait_n are driven back.
interface msx_ppi_io_responder_if;
  logic [7:0] a;
  logic [7:0] d_in;
  logic [7:0] d_out;
  logic       d_oe;
  logic       iorq_n;
  logic       rd_n;
  logic       wr_n;
  logic       m1_n;
  logic       wait_n;

  modport master (
    output a, d_in, iorq_n, rd_n, wr_n, m1_n,
    input  d_out, d_oe, wait_n
  );

  modport slave (
    input  a, d_in, iorq_n, rd_n, wr_n, m1_n,
    output d_out, d_oe, wait_n
  );
endinterface

// File: rtl/msx_ppi_io_responder_sync2.sv
// Two-flop synchronizer for one active-low Z80 strobe.
// Ports: clk, rst (async, active-high), async_in (raw strobe),
// sync_out (synchronized strobe, resets to 1 = inactive).
module msx_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic sync_out
);

  logic meta_r;
  logic sync_r;

  // Two-stage capture; reset to the inactive (high) level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_r <= 1'b1;
      sync_r <= 1'b1;
    end else begin
      meta_r <= async_in;
      sync_r <= meta_r;
    end
  end

  assign sync_out = sync_r;

endmodule

// File: rtl/msx_ppi_io_responder.sv
// Z80 I/O responder for ports A8h-ABh: primary slot register, keyboard column
// readback, port C outputs and port C bit set/reset, with a deterministic
// WAIT_n stretch of WAIT_CYCLES clk per answered cycle.
// Ports: clk, rst (async, active-high), bus (slave side of the Z80 I/O bus),
// slot_sel (A8h register), port_c (AAh outputs), kbd_col (read on A9h).
// Parameter WAIT_CYCLES: clk cycles wait_n is held low (0 = no wait, max 256).
module msx_ppi_io_responder
  import msx_io_pkg::*;
#(
  parameter int WAIT_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  msx_ppi_io_responder_if.slave  bus,
  output logic [7:0]             slot_sel,
  output logic [7:0]             port_c,
  input  logic [7:0]             kbd_col
);

  localparam bit         NO_WAIT   = (WAIT_CYCLES == 0);
  localparam logic [7:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 8'(WAIT_CYCLES - 1) : 8'd0;

  logic       iorq_s;
  logic       rd_s;
  logic       wr_s;
  logic       m1_s;
  logic       req_s;

  state_t     state_r;
  logic [7:0] cnt_r;
  logic       wr_cyc_r;
  logic [7:0] slot_sel_r;
  logic [7:0] port_c_r;
  logic [7:0] d_out_r;
  logic       d_oe_r;
  logic       wait_n_r;

  msx_sync2 u_sync_iorq (.clk(clk), .rst(rst), .async_in(bus.iorq_n), .sync_out(iorq_s));
  msx_sync2 u_sync_rd   (.clk(clk), .rst(rst), .async_in(bus.rd_n),   .sync_out(rd_s));
  msx_sync2 u_sync_wr   (.clk(clk), .rst(rst), .async_in(bus.wr_n),   .sync_out(wr_s));
  msx_sync2 u_sync_m1   (.clk(clk), .rst(rst), .async_in(bus.m1_n),   .sync_out(m1_s));

  // Request decode: I/O cycle (not interrupt acknowledge), exactly one of RD/WR, our port block
  always_comb begin
    req_s = 1'b0;
    if (!iorq_s && m1_s && (rd_s ^ wr_s) && (bus.a[7:2] == PORT_BASE)) begin
      req_s = 1'b1;
    end else begin
      req_s = 1'b0;
    end
  end

  // Bus-cycle FSM with all registers and registered bus outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      cnt_r      <= RST_CNT;
      wr_cyc_r   <= 1'b0;
      slot_sel_r <= RST_SLOT_SEL;
      port_c_r   <= RST_PORT_C;
      d_out_r    <= RST_D_OUT;
      d_oe_r     <= RST_D_OE;
      wait_n_r   <= RST_WAIT_N;
    end else begin
      case (state_r)
        ST_IDLE: begin
          d_oe_r   <= 1'b0;
          wait_n_r <= 1'b1;
          if (req_s) begin
            // direction is latched here; ACCESS does not re-decode the strobes
            wr_cyc_r <= ~wr_s;
            if (NO_WAIT) begin
              state_r <= ST_ACCESS;
            end else begin
              state_r  <= ST_WAIT;
              wait_n_r <= 1'b0;
              cnt_r    <= WAIT_LOAD;
            end
          end
        end

        ST_WAIT: begin
          // an IORQ release takes priority over finishing the count
          if (iorq_s) begin
            state_r  <= ST_IDLE;
            wait_n_r <= 1'b1;
            cnt_r    <= RST_CNT;
          end else if (cnt_r == 8'd0) begin
            state_r  <= ST_ACCESS;
            wait_n_r <= 1'b1;
          end else begin
            cnt_r <= cnt_r - 8'd1;
          end
        end

        ST_ACCESS: begin
          state_r <= ST_HOLD;
          if (wr_cyc_r) begin
            case (bus.a)
              PORT_SLOT: slot_sel_r <= bus.d_in;
              PORT_C:    port_c_r   <= bus.d_in;
              PORT_CTRL: port_c_r   <= port_c_ctrl(port_c_r, bus.d_in);
              default:   ; // A9h write is ignored
            endcase
          end else begin
            d_oe_r <= 1'b1;
            case (bus.a)
              PORT_SLOT: d_out_r <= slot_sel_r;
              PORT_KBD:  d_out_r <= kbd_col;
              PORT_C:    d_out_r <= port_c_r;
              default:   d_out_r <= 8'hFF;
            endcase
          end
        end

        ST_HOLD: begin
          // one response per bus cycle: wait for IORQ to go away
          if (iorq_s) begin
            state_r <= ST_IDLE;
            d_oe_r  <= 1'b0;
          end
        end

        default: begin
          state_r  <= ST_IDLE;
          d_oe_r   <= 1'b0;
          wait_n_r <= 1'b1;
        end
      endcase
    end
  end

  assign slot_sel   = slot_sel_r;
  assign port_c     = port_c_r;
  assign bus.d_out  = d_out_r;
  assign bus.d_oe   = d_oe_r;
  assign bus.wait_n = wait_n_r;

endmodule

// File: doc/msx_ppi_io_responder.md
# msx_ppi_io_responder

I/O-bus responder for the MSX engine's Z80 side: it answers the CPU's I/O read and write cycles on ports A8h–ABh. It implements the 8255-lite subset the system needs: the primary slot-select register, keyboard column readback, port C outputs, and port C bit set/reset. It sits between the Z80 bus glue logic and the slot/memory decoders. It also generates WAIT_n so that slow-clocked CPU cycles are met deterministically.

## Interface
Parameters:
- WAIT_CYCLES, 2: clk cycles WAIT_n is held low per responded cycle; 0 is legal and means no wait.

Ports:
- clk  in  1  system clock; one clock domain, at least 4x the Z80 clock.
- rst  in  1  reset, asynchronous and active-high.
- a  in  8  Z80 address A7..A0.
- d_in  in  8  Z80 data bus, input side.
- d_out  out  8  read data.
- d_oe  out  1  data bus output enable.
- iorq_n  in  1  Z80 IORQ, active-low, asynchronous to clk.
- rd_n  in  1  Z80 RD, active-low, asynchronous to clk.
- wr_n  in  1  Z80 WR, active-low, asynchronous to clk.
- m1_n  in  1  Z80 M1, active-low, asynchronous to clk.
- wait_n  out  1  Z80 WAIT, active-low.
- slot_sel  out  8  primary slot register (port A8h).
- port_c  out  8  PPI port C outputs (port AAh).
- kbd_col  in  8  keyboard column input, read on port A9h.

## Operation
- iorq_n, rd_n, wr_n and m1_n each pass through a 2-flop synchronizer. a and d_in are sampled raw; they are stable while IORQ is low.
- Request: sync iorq low, sync m1 high, exactly one of sync rd or sync wr low, and a[7:2] == 6'b101010.
- rd and wr both low: no response.
- Interrupt acknowledge (m1 low with iorq low): no response.
- FSM states IDLE, WAIT, ACCESS, HOLD.
  - IDLE → WAIT on request. If WAIT_CYCLES = 0, IDLE → ACCESS instead.
  - WAIT: wait_n = 0. A counter runs from WAIT_CYCLES-1 down to 0, then the FSM goes to ACCESS.
  - WAIT → IDLE if sync iorq goes high (aborted cycle). No register update in that case.
  - ACCESS lasts one clk. It performs the write, or latches d_out and asserts d_oe for a read. It always goes to HOLD next.
  - HOLD stays until sync iorq is high, then goes to IDLE. d_oe drops on that same clk edge.
  - HOLD waiting for iorq high guarantees one response per bus cycle.
- Writes (value in d_in captured in ACCESS):
  - A8h: slot_sel = d_in.
  - A9h: ignored.
  - AAh: port_c = d_in.
  - ABh with d_in[7] = 0: bit set/reset, port_c[d_in[3:1]] = d_in[0].
  - ABh with d_in[7] = 1: mode word, port_c cleared to 00h.
- Reads (d_out loaded in ACCESS):
  - A8h: slot_sel.
  - A9h: kbd_col, sampled in the ACCESS clk.
  - AAh: port_c.
  - ABh: FFh.
- Non-matching addresses: no response. FSM stays IDLE, wait_n = 1, d_oe = 0.

## Timing
- Reset values (asynchronous, immediate): slot_sel = 00h, port_c = 00h, d_out = 00h, d_oe = 0, wait_n = 1, FSM = IDLE, counter = 0.
- Reset asserted mid-cycle releases wait_n and d_oe at once.
- wait_n is registered. It falls 3 clk after the iorq_n falling edge reaches the synchronizer (2 sync + 1 decode). It stays low exactly WAIT_CYCLES clk.
- The write takes effect on slot_sel/port_c at the ACCESS clk edge, WAIT_CYCLES+1 clk after entering WAIT.
- Read data is valid and d_oe = 1 from that same edge until sync iorq high.
- Back-to-back I/O cycles are handled because HOLD → IDLE → WAIT takes at least 2 clk, well inside the Z80 inter-cycle gap.
- A write while WAIT is active is not visible on outputs until ACCESS.

## Structure
- Shared package msx_io_pkg:
  - port address constants PORT_SLOT = 8'hA8, PORT_KBD = 8'hA9, PORT_C = 8'hAA, PORT_CTRL = 8'hAB.
  - FSM state typedef.
  - reset value constants.
- Sub-module msx_sync2: a 2-flop synchronizer with asynchronous reset to 1 (inactive). It is instantiated once per strobe.

## Test plan
- Reset: assert rst mid-WAIT → wait_n = 1, d_oe = 0, slot_sel = 00h, port_c = 00h immediately.
- Write A8h = 5Ah, WAIT_CYCLES = 2 → wait_n low exactly 2 clk, then slot_sel = 5Ah. A read of A8h afterwards returns 5Ah with d_oe = 1 until IORQ rises.
- Port C bit set/reset:
  - Write AAh = 00h, then ABh = 07h → port_c = 08h.
  - Then write ABh = 06h → port_c = 00h.
  - Then write ABh = 80h after port_c = FFh → port_c = 00h.
- kbd_col = C3h, read A9h → d_out = C3h. Also read ABh → FFh.
- Non-responses:
  - I/O write to port 98h → no wait_n, registers unchanged.
  - Interrupt acknowledge (m1_n = 0, iorq_n = 0) at a = A8h → no response.
- Abort: iorq_n rises during WAIT on a write of A8h = 11h → FSM returns to IDLE, slot_sel unchanged. WAIT_CYCLES = 0 build → wait_n never asserted, write still completes.
